pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the IF/ID/EX core.
- Detects load-use hazards between the decode stage's source registers and a load in EX.
- Stalls the whole pipe while a data-memory access waits for acknowledge.
- Flushes IF/ID and ID/EX and redirects the PC on jumps and taken branches.
- Drives the hold/flush inputs of the PC register, the IF/ID register and the ID/EX register.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_if.sv | 50 +++++
 rtl/pipe_ctrl_perf_cnt.sv | 14 +
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the IF/ID/EX pipeline controller: state encodings,
// register/address widths and the load-use hazard test.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int INST_ADDR_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;

    typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    typedef enum logic [1:0] {
        PIPE_RUN        = 2'd0,
        PIPE_LOAD_STALL = 2'd1,
        PIPE_MEM_WAIT   = 2'd2,
        PIPE_FLUSH      = 2'd3
    } pipe_state_e;

    // x0 is hard-wired, so a load targeting it never creates a dependency.
    function automatic logic load_use_hz(logic is_load, reg_addr_t rd,
                                         reg_addr_t rs1, reg_addr_t rs2);
        return is_load && (rd != ZERO_REG_ADDR) && (rd == rs1 || rd == rs2);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/EX/memory status in, hold/flush/redirect controls out.
// PIPE_CTRL_PERF_EN adds the stall/flush performance counters.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    reg_addr_t  id_reg1_rd_addr_i;
    reg_addr_t  id_reg2_rd_addr_i;
    logic       ex_is_load_i;
    reg_addr_t  ex_reg_wr_addr_i;
    logic       jump_flag_i;
    inst_addr_t jump_addr_i;
    logic       mem_req_i;
    logic       mem_ack_i;

    logic       hold_pc_o;
    logic       hold_if_id_o;
    logic       hold_id_ex_o;
    logic       flush_if_id_o;
    logic       flush_id_ex_o;
    logic       pc_load_o;
    inst_addr_t pc_target_o;
    logic       mem_abort_o;
    logic       err_o;
    logic       busy_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    modport master (
        output id_reg1_rd_addr_i, id_reg2_rd_addr_i, ex_is_load_i, ex_reg_wr_addr_i,
               jump_flag_i, jump_addr_i, mem_req_i, mem_ack_i,
        input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
               pc_load_o, pc_target_o, mem_abort_o, err_o, busy_o
`ifdef PIPE_CTRL_PERF_EN
        , input stall_cnt_o, flush_cnt_o
`endif
    );

    modport slave (
        input  id_reg1_rd_addr_i, id_reg2_rd_addr_i, ex_is_load_i, ex_reg_wr_addr_i,
               jump_flag_i, jump_addr_i, mem_req_i, mem_ack_i,
        output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
               pc_load_o, pc_target_o, mem_abort_o, err_o, busy_o
`ifdef PIPE_CTRL_PERF_EN
        , output stall_cnt_o, flush_cnt_o
`endif
    );

endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// Saturating 32-bit event counter; only built with PIPE_CTRL_PERF_EN.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);
    always_ff @(posedge clk) begin
        if (rst)                       cnt_o <= '0;
        else if (inc_i && cnt_o != '1) cnt_o <= cnt_o + 32'd1;
    end
endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, memory-wait holds and
// redirect flushes. PIPE_CTRL_PERF_EN adds stall/flush cycle counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    pipe_state_e state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        pend_jump, pend_jump_n;
    inst_addr_t  pend_addr, pend_addr_n;
    logic        redir, redir_n;

    logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
    logic        pc_load, mem_abort, err;
    inst_addr_t  pc_target;
    logic        hz;

    assign hz = load_use_hz(bus.ex_is_load_i, bus.ex_reg_wr_addr_i,
                            bus.id_reg1_rd_addr_i, bus.id_reg2_rd_addr_i);

    always_comb begin
        hold_pc = 1'b0; hold_if_id = 1'b0; hold_id_ex = 1'b0;
        flush_if_id = 1'b0; flush_id_ex = 1'b0;
        pc_load = 1'b0; pc_target = '0; mem_abort = 1'b0; err = 1'b0;
        state_n = state; cnt_n = cnt; pend_jump_n = pend_jump;
        pend_addr_n = pend_addr; redir_n = 1'b0;
        case (state)
            PIPE_RUN: begin
                if (bus.mem_req_i && !bus.mem_ack_i) begin
                    {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
                    state_n = PIPE_MEM_WAIT;
                    cnt_n   = 8'd1;
                    // EX is frozen, so the redirect is replayed once memory completes.
                    if (bus.jump_flag_i) begin
                        pend_jump_n = 1'b1;
                        pend_addr_n = bus.jump_addr_i;
                    end
                end else if (bus.jump_flag_i) begin
                    pc_load = 1'b1; pc_target = bus.jump_addr_i;
                    flush_if_id = 1'b1; flush_id_ex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_n = PIPE_FLUSH;
                        cnt_n   = 8'(FLUSH_CYCLES - 1);
                    end
                end else if (hz) begin
                    hold_pc = 1'b1; hold_if_id = 1'b1; flush_id_ex = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_n = PIPE_LOAD_STALL;
                        cnt_n   = 8'(LOAD_BUBBLES - 1);
                    end
                end
            end
            PIPE_LOAD_STALL: begin
                hold_pc = 1'b1; hold_if_id = 1'b1; flush_id_ex = 1'b1;
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) state_n = PIPE_RUN;
            end
            PIPE_MEM_WAIT: begin
                {hold_pc, hold_if_id, hold_id_ex} = {3{!bus.mem_ack_i}};
                if (bus.mem_ack_i) begin
                    if (pend_jump) begin
                        state_n     = PIPE_FLUSH;
                        cnt_n       = 8'(FLUSH_CYCLES);
                        pend_jump_n = 1'b0;
                        redir_n     = 1'b1;
                    end else begin
                        state_n = PIPE_RUN;
                    end
                end else if (cnt == 8'(MEM_TIMEOUT)) begin
                    {hold_pc, hold_if_id, hold_id_ex} = 3'b000;
                    mem_abort   = 1'b1;
                    err         = 1'b1;
                    pend_jump_n = 1'b0;
                    state_n     = PIPE_RUN;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            PIPE_FLUSH: begin
                flush_if_id = 1'b1; flush_id_ex = 1'b1;
                if (redir) begin
                    pc_load   = 1'b1;
                    pc_target = pend_addr;
                end
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) state_n = PIPE_RUN;
            end
            default: state_n = PIPE_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PIPE_RUN;
            cnt       <= '0;
            pend_jump <= 1'b0;
            pend_addr <= '0;
            redir     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pend_jump <= pend_jump_n;
            pend_addr <= pend_addr_n;
            redir     <= redir_n;
        end
    end

    // Outputs are silenced while reset is held, whatever the state register holds.
    assign bus.hold_pc_o     = !rst && hold_pc;
    assign bus.hold_if_id_o  = !rst && hold_if_id;
    assign bus.hold_id_ex_o  = !rst && hold_id_ex;
    assign bus.flush_if_id_o = !rst && flush_if_id;
    assign bus.flush_id_ex_o = !rst && flush_id_ex;
    assign bus.pc_load_o     = !rst && pc_load;
    assign bus.pc_target_o   = rst ? '0 : pc_target;
    assign bus.mem_abort_o   = !rst && mem_abort;
    assign bus.err_o         = !rst && err;
    assign bus.busy_o        = !rst && (state != PIPE_RUN);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    pipe_perf_cnt u_stall_cnt (.clk(clk), .rst(rst), .inc_i(bus.hold_pc_o),     .cnt_o(stall_cnt));
    pipe_perf_cnt u_flush_cnt (.clk(clk), .rst(rst), .inc_i(bus.flush_id_ex_o), .cnt_o(flush_cnt));

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with default parameters: hazards, redirects,
// memory waits, timeout, deferred jump and reset behaviour.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.LOAD_BUBBLES(1), .FLUSH_CYCLES(2), .MEM_TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Flag order: hold_pc hold_if_id hold_id_ex flush_if_id flush_id_ex pc_load mem_abort err busy
    localparam logic [8:0] F_IDLE      = 9'b000000000;
    localparam logic [8:0] F_HZ        = 9'b110010000;
    localparam logic [8:0] F_JMP       = 9'b000111000;
    localparam logic [8:0] F_FL        = 9'b000110001;
    localparam logic [8:0] F_FL_REDIR  = 9'b000111001;
    localparam logic [8:0] F_HOLD_RUN  = 9'b111000000;
    localparam logic [8:0] F_HOLD_WAIT = 9'b111000001;
    localparam logic [8:0] F_WAIT_ACK  = 9'b000000001;
    localparam logic [8:0] F_ABORT     = 9'b000000111;

    task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic jmp, input logic [31:0] ja,
                         input logic mreq, input logic mack);
        bus.ex_is_load_i      = ld;
        bus.ex_reg_wr_addr_i  = rd;
        bus.id_reg1_rd_addr_i = rs1;
        bus.id_reg2_rd_addr_i = rs2;
        bus.jump_flag_i       = jmp;
        bus.jump_addr_i       = ja;
        bus.mem_req_i         = mreq;
        bus.mem_ack_i         = mack;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] ef, input logic [31:0] et);
        logic [8:0] of;
        #2;
        of = {bus.hold_pc_o, bus.hold_if_id_o, bus.hold_id_ex_o, bus.flush_if_id_o,
              bus.flush_id_ex_o, bus.pc_load_o, bus.mem_abort_o, bus.err_o, bus.busy_o};
        vectors++;
        assert (of === ef) else begin
            miscompares++;
            $error("FAIL %s flags: got %b want %b", tag, of, ef);
        end
        vectors++;
        assert (bus.pc_target_o === et) else begin
            miscompares++;
            $error("FAIL %s pc_target: got %h want %h", tag, bus.pc_target_o, et);
        end
    endtask

    initial begin
        // Reset with live requests on the inputs: everything must stay quiet.
        rst = 1'b1;
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 32'h40, 1'b1, 1'b0);
        check("reset_forced", F_IDLE, 32'h0);
        step();
        rst = 1'b0;
        idle();
        check("after_reset", F_IDLE, 32'h0);

        // Load-use on rs2, one bubble then back to normal flow.
        step();
        drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
        check("hz_rs2", F_HZ, 32'h0);
        step();
        idle();
        check("hz_done", F_IDLE, 32'h0);

        step();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("hz_x0", F_IDLE, 32'h0);
        step();
        drive(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 32'h0, 1'b0, 1'b0);
        check("hz_rs1", F_HZ, 32'h0);
        step();
        drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
        check("store_no_hz", F_IDLE, 32'h0);

        // Jump 0x100: redirect cycle plus one FLUSH cycle.
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        check("jump_run", F_JMP, 32'h0000_0100);
        step();
        idle();
        check("jump_flush", F_FL, 32'h0);
        step();
        check("jump_done", F_IDLE, 32'h0);

        // Jump beats a simultaneous hazard.
        step();
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        check("jump_over_hz", F_JMP, 32'h0000_0080);
        step();
        idle();
        check("jump_over_hz_fl", F_FL, 32'h0);
        step();
        check("jump_over_hz_done", F_IDLE, 32'h0);

        // Memory access acknowledged after three held cycles.
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("mem_hold0", F_HOLD_RUN, 32'h0);
        step();
        check("mem_hold1", F_HOLD_WAIT, 32'h0);
        step();
        check("mem_hold2", F_HOLD_WAIT, 32'h0);
        step();
        bus.mem_ack_i = 1'b1;
        check("mem_ack", F_WAIT_ACK, 32'h0);
        step();
        idle();
        check("mem_done", F_IDLE, 32'h0);

        // Same-cycle ack in RUN: no hold, hazard still seen.
        step();
        drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 32'h0, 1'b1, 1'b1);
        check("mem_fast_hz", F_HZ, 32'h0);

        // No ack: timeout on the 16th wait count.
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("to_run", F_HOLD_RUN, 32'h0);
        for (int i = 1; i < 16; i++) begin
            step();
            check("to_wait", F_HOLD_WAIT, 32'h0);
        end
        step();
        check("to_abort", F_ABORT, 32'h0);
        step();
        idle();
        check("to_after", F_IDLE, 32'h0);

        // Ack arriving in the timeout cycle wins.
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("race_run", F_HOLD_RUN, 32'h0);
        for (int i = 1; i < 16; i++) begin
            step();
            check("race_wait", F_HOLD_WAIT, 32'h0);
        end
        step();
        bus.mem_ack_i = 1'b1;
        check("race_ack", F_WAIT_ACK, 32'h0);
        step();
        idle();
        check("race_after", F_IDLE, 32'h0);

        // Jump coincident with stalled access: deferred until ack.
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
        check("pj_run", F_HOLD_RUN, 32'h0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("pj_wait", F_HOLD_WAIT, 32'h0);
        step();
        bus.mem_ack_i = 1'b1;
        check("pj_ack", F_WAIT_ACK, 32'h0);
        step();
        idle();
        check("pj_redir", F_FL_REDIR, 32'h0000_0200);
        step();
        check("pj_flush2", F_FL, 32'h0);
        step();
        check("pj_done", F_IDLE, 32'h0);

        // Reset during MEM_WAIT with a pending jump discards it.
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
        check("rpj_run", F_HOLD_RUN, 32'h0);
        step();
        bus.jump_flag_i = 1'b0;
        check("rpj_wait", F_HOLD_WAIT, 32'h0);
        step();
        rst = 1'b1;
        check("rpj_rst", F_IDLE, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("rpj_run_after", F_IDLE, 32'h0);
        step();
        idle();
        check("rpj_no_load1", F_IDLE, 32'h0);
        step();
        check("rpj_no_load2", F_IDLE, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
